// File: rtl/key_session_pkg.sv
// Shared types and constants for the session key loader.
package key_session_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SCRUB  = 2'd2
    } state_e;

    // Widest key supported; narrower keys take the low bits of the patterns.
    localparam int unsigned KEY_W_MAX = 256;

    localparam logic [KEY_W_MAX-1:0] SCRUB_FIRST = '1;
    localparam logic [KEY_W_MAX-1:0] SCRUB_REST  = '0;

endpackage

// File: rtl/key_session_loader_if.sv
// Load/use/scrub bus between key provisioning, the loader and the encryptor.
interface key_session_loader_if #(
    parameter int unsigned KEY_W    = 32,
    parameter int unsigned MAX_USES = 5
);
    localparam int unsigned UW = $clog2(MAX_USES + 1);

    logic             key_load_valid;
    logic [KEY_W-1:0] key_load_data;
    logic             key_load_ready;
    logic             session_end;
    logic             use_req;
    logic             use_ack;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic [UW-1:0]    uses_left;
    logic             scrubbing;
    logic             scrub_done;

    modport master (
        output key_load_valid, key_load_data, session_end, use_req,
        input  key_load_ready, use_ack, key_out, key_valid, uses_left,
               scrubbing, scrub_done
    );

    modport slave (
        input  key_load_valid, key_load_data, session_end, use_req,
        output key_load_ready, use_ack, key_out, key_valid, uses_left,
               scrubbing, scrub_done
    );
endinterface

// File: rtl/key_scrub_seq.sv
// Scrub sequencer: counts the scrub cycles and supplies the overwrite pattern.
module key_scrub_seq
    import key_session_pkg::*;
#(
    parameter int unsigned KEY_W        = 32,
    parameter int unsigned SCRUB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic [KEY_W-1:0] pattern,
    output logic             last_c,
    output logic             done
);
    localparam int unsigned CW = $clog2(SCRUB_CYCLES);

    logic [CW-1:0] cnt;

    assign last_c = busy && (cnt == CW'(SCRUB_CYCLES - 1));

    // Counter, pattern and done pulse; pattern is all-ones only in scrub cycle 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            busy    <= 1'b0;
            pattern <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy    <= 1'b1;
                cnt     <= '0;
                pattern <= KEY_W'(SCRUB_FIRST);
            end else if (busy) begin
                pattern <= KEY_W'(SCRUB_REST);
                if (last_c) begin
                    busy <= 1'b0;
                    cnt  <= '0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/key_session_loader.sv
// Holds one session key for a bounded number of uses, then scrubs it.
module key_session_loader
    import key_session_pkg::*;
#(
    parameter int unsigned KEY_W        = 32,
    parameter int unsigned MAX_USES     = 5,
    parameter int unsigned SCRUB_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    key_session_loader_if.slave  bus
);
    localparam int unsigned UW = $clog2(MAX_USES + 1);

    state_e           state;
    state_e           next_state;
    logic [KEY_W-1:0] key_reg;
    logic [UW-1:0]    uses_q;
    logic             scrub_start_c;
    logic             seq_busy;
    logic             seq_last_c;
    logic             seq_done;
    logic [KEY_W-1:0] seq_pattern;
    logic             ack_c;

    assign ack_c = (state == ST_ACTIVE) && bus.use_req && !bus.session_end;

    key_scrub_seq #(
        .KEY_W        (KEY_W),
        .SCRUB_CYCLES (SCRUB_CYCLES)
    ) u_scrub (
        .clk     (clk),
        .rst     (rst),
        .start   (scrub_start_c),
        .busy    (seq_busy),
        .pattern (seq_pattern),
        .last_c  (seq_last_c),
        .done    (seq_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_EMPTY;
        else     state <= next_state;
    end

    // Next-state decode; revoke beats a simultaneous use.
    always_comb begin
        next_state    = state;
        scrub_start_c = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (bus.key_load_valid) next_state = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (bus.session_end || (ack_c && uses_q == UW'(1))) begin
                    next_state    = ST_SCRUB;
                    scrub_start_c = 1'b1;
                end
            end
            ST_SCRUB: begin
                if (seq_last_c) next_state = ST_EMPTY;
            end
            default: next_state = ST_EMPTY;
        endcase
    end

    // Key register and remaining-use counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg <= '0;
            uses_q  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (bus.key_load_valid) begin
                        key_reg <= bus.key_load_data;
                        uses_q  <= UW'(MAX_USES);
                    end
                end
                ST_ACTIVE: begin
                    if (scrub_start_c) uses_q <= '0;
                    else if (ack_c)    uses_q <= uses_q - UW'(1);
                end
                ST_SCRUB: key_reg <= seq_pattern;
                default:  key_reg <= '0;
            endcase
        end
    end

    assign bus.use_ack        = ack_c;
    assign bus.key_valid      = (state == ST_ACTIVE);
    assign bus.key_out        = (state == ST_ACTIVE) ? key_reg : '0;
    assign bus.key_load_ready = (state == ST_EMPTY);
    assign bus.uses_left      = uses_q;
    assign bus.scrubbing      = seq_busy;
    assign bus.scrub_done     = seq_done;
endmodule

// File: tb/tb_key_session_loader.sv
// Directed bench for key_session_loader.
module tb_key_session_loader;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    key_session_loader_if #(.KEY_W(32), .MAX_USES(5)) bus ();

    key_session_loader #(
        .KEY_W        (32),
        .MAX_USES     (5),
        .SCRUB_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs settled 2 time units later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.key_load_valid = 1'b0;
        bus.key_load_data  = '0;
        bus.session_end    = 1'b0;
        bus.use_req        = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"},     64'(bus.key_load_ready), 64'(1));
        chk({tag, "_valid"},     64'(bus.key_valid), 64'(0));
        chk({tag, "_key_out"},   64'(bus.key_out), 64'(0));
        chk({tag, "_uses"},      64'(bus.uses_left), 64'(0));
        chk({tag, "_scrubbing"}, 64'(bus.scrubbing), 64'(0));
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();

        // Reset defaults
        chk_idle("rst");
        chk("rst_ack",  64'(bus.use_ack), 64'(0));
        chk("rst_done", 64'(bus.scrub_done), 64'(0));

        // Full session: load DEADBEEF, five back-to-back uses
        bus.key_load_valid = 1'b1;
        bus.key_load_data  = 32'hDEADBEEF;
        tick();
        idle_inputs();
        chk("load_valid", 64'(bus.key_valid), 64'(1));
        chk("load_ready", 64'(bus.key_load_ready), 64'(0));
        for (int i = 0; i < 5; i++) begin
            bus.use_req = 1'b1;
            #1;
            chk($sformatf("full_ack%0d", i),  64'(bus.use_ack), 64'(1));
            chk($sformatf("full_uses%0d", i), 64'(bus.uses_left), 64'(5 - i));
            chk($sformatf("full_key%0d", i),  64'(bus.key_out), 64'(32'hDEADBEEF));
            tick();
        end
        idle_inputs();
        // Scrub cycle 0
        chk("scr0_scrubbing", 64'(bus.scrubbing), 64'(1));
        chk("scr0_valid",     64'(bus.key_valid), 64'(0));
        chk("scr0_key_out",   64'(bus.key_out), 64'(0));
        chk("scr0_uses",      64'(bus.uses_left), 64'(0));
        chk("scr0_done",      64'(bus.scrub_done), 64'(0));
        tick();
        chk("scr1_keyreg",    64'(dut.key_reg), 64'(32'hFFFFFFFF));
        chk("scr1_key_out",   64'(bus.key_out), 64'(0));
        chk("scr1_done",      64'(bus.scrub_done), 64'(0));
        tick();
        chk("scr2_keyreg",    64'(dut.key_reg), 64'(0));
        chk("scr2_scrubbing", 64'(bus.scrubbing), 64'(1));
        tick();
        chk("scr3_scrubbing", 64'(bus.scrubbing), 64'(1));
        chk("scr3_ready",     64'(bus.key_load_ready), 64'(0));
        chk("scr3_done",      64'(bus.scrub_done), 64'(0));
        tick();
        chk("end_done",       64'(bus.scrub_done), 64'(1));
        chk_idle("end");
        tick();
        chk("end_done_drop",  64'(bus.scrub_done), 64'(0));

        // Early revoke with a load attempt during ACTIVE
        bus.key_load_valid = 1'b1;
        bus.key_load_data  = 32'h12345678;
        tick();
        bus.key_load_data  = 32'hA5A5A5A5;
        #1;
        chk("ign_ready", 64'(bus.key_load_ready), 64'(0));
        tick();
        idle_inputs();
        chk("ign_key",  64'(bus.key_out), 64'(32'h12345678));
        chk("ign_uses", 64'(bus.uses_left), 64'(5));
        bus.use_req = 1'b1;
        tick(); tick();
        chk("rev_uses_pre", 64'(bus.uses_left), 64'(3));
        bus.session_end = 1'b1;
        #1;
        chk("rev_ack", 64'(bus.use_ack), 64'(0));
        tick();
        idle_inputs();
        chk("rev_uses",      64'(bus.uses_left), 64'(0));
        chk("rev_scrubbing", 64'(bus.scrubbing), 64'(1));
        chk("rev_valid",     64'(bus.key_valid), 64'(0));
        // use_req and session_end during SCRUB do nothing
        bus.use_req     = 1'b1;
        bus.session_end = 1'b1;
        #1;
        chk("scrub_use_ack", 64'(bus.use_ack), 64'(0));
        tick();
        idle_inputs();
        // Reset in scrub cycle 1
        chk("rst_mid_keyreg_pre", 64'(dut.key_reg), 64'(32'hFFFFFFFF));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("rst_mid");
        chk("rst_mid_keyreg", 64'(dut.key_reg), 64'(0));
        chk("rst_mid_done0",  64'(bus.scrub_done), 64'(0));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rst_mid_nodone%0d", i), 64'(bus.scrub_done), 64'(0));
        end

        // Reload on the scrub_done cycle with an all-zero key
        bus.key_load_valid = 1'b1;
        bus.key_load_data  = 32'h11111111;
        tick();
        idle_inputs();
        bus.use_req = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) tick();
        chk("rl_done",  64'(bus.scrub_done), 64'(1));
        chk("rl_ready", 64'(bus.key_load_ready), 64'(1));
        bus.key_load_valid = 1'b1;
        bus.key_load_data  = 32'h0;
        tick();
        idle_inputs();
        chk("rl_valid", 64'(bus.key_valid), 64'(1));
        chk("rl_key",   64'(bus.key_out), 64'(0));
        chk("rl_uses",  64'(bus.uses_left), 64'(5));
        chk("rl_done_drop", 64'(bus.scrub_done), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
